// File: rtl/wave_led_pkg.sv
// wave_led_pkg: shared types for the wave_LED scheduler.
// Pattern code type, FSM states and round-robin owner encoding.
package wave_led_pkg;

  typedef logic [2:0] pattern_code_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    GAP
  } sched_state_t;

  localparam pattern_code_t PATTERN_OFF = 3'd0;

  localparam logic RR_A = 1'b0;
  localparam logic RR_B = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/wave_led_req_fifo.sv
// wave_led_req_fifo: synchronous request queue, power-of-two depth.
// Push ignored when full, pop ignored when empty, flush empties it.
module wave_led_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage array, written on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= din_i;
    end
  end

  // Pointers wrap modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/wave_led_scheduler.sv
// wave_led_scheduler: arbitrates two requesters into a queue and
// paces wave_LED launches. Macro WAVE_LED_SCHED_REPEAT_EN relaunches.
module wave_led_scheduler
  import wave_led_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int START_CYCLES = 2,
  parameter int SEQ_CYCLES   = 13_500_000,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [2:0] code_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [2:0] code_b,
  output logic       ack_b,
  input  logic       abort,
  output logic [2:0] signal,
  output logic       start_sequence,
  output logic       busy,
  output logic       fifo_full
);

  localparam int CNT_MAX = max3(START_CYCLES, SEQ_CYCLES, GAP_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FCW     = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] SEQ_LAST   = CNT_W'(SEQ_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  sched_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pattern_code_t signal_q, signal_d;
  logic          start_q;
  logic          busy_q;
  logic          ack_a_q;
  logic          ack_b_q;
  logic          rr_q, rr_d;

  logic          elig_a, elig_b;
  logic          grant_a, grant_b;
  logic          push;
  logic          pop;
  pattern_code_t push_code;
  pattern_code_t fifo_dout;
  logic [FCW-1:0] fifo_cnt;
  logic          fifo_full_w;
  logic          fifo_empty;
  logic          room;

  assign room = (fifo_cnt < FCW'(FIFO_DEPTH));

  wave_led_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (3)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (abort),
    .push_i  (push),
    .din_i   (push_code),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_cnt),
    .full_o  (fifo_full_w),
    .empty_o (fifo_empty)
  );

  // Round-robin arbiter; a requester sits out the cycle of its own ack.
  always_comb begin
    elig_a    = req_a & ~ack_a_q & ~abort & room;
    elig_b    = req_b & ~ack_b_q & ~abort & room;
    grant_a   = elig_a & (~elig_b | (rr_q == RR_A));
    grant_b   = elig_b & (~elig_a | (rr_q == RR_B));
    push      = grant_a | grant_b;
    push_code = grant_a ? code_a : code_b;
    rr_d      = rr_q;
    if (elig_a && elig_b) begin
      rr_d = ~rr_q;
    end
  end

`ifdef WAVE_LED_SCHED_REPEAT_EN
  logic done_q;

  // Remembers that a pattern ran to completion since reset or abort.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      done_q <= 1'b0;
    end else if (state_q == GAP && state_d == IDLE) begin
      done_q <= 1'b1;
    end
  end
`endif

  // Launch sequencer next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    signal_d = signal_q;
    pop      = 1'b0;
    if (abort) begin
      state_d  = IDLE;
      cnt_d    = '0;
      signal_d = PATTERN_OFF;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            signal_d = fifo_dout;
            state_d  = START;
            cnt_d    = '0;
          end
`ifdef WAVE_LED_SCHED_REPEAT_EN
          else if (done_q) begin
            state_d = START;
            cnt_d   = '0;
          end
`endif
        end
        START: begin
          if (cnt_q == START_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        RUN: begin
          if (cnt_q == SEQ_LAST) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      signal_q <= PATTERN_OFF;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      rr_q     <= RR_A;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      signal_q <= signal_d;
      start_q  <= (state_d == START);
      busy_q   <= (state_d != IDLE);
      ack_a_q  <= grant_a;
      ack_b_q  <= grant_b;
      rr_q     <= rr_d;
    end
  end

  assign signal         = signal_q;
  assign start_sequence = start_q;
  assign busy           = busy_q;
  assign ack_a          = ack_a_q;
  assign ack_b          = ack_b_q;
  assign fifo_full      = fifo_full_w;

endmodule

// File: tb/tb_wave_led_scheduler.sv
// tb_wave_led_scheduler: directed tests for wave_led_scheduler.
// SEQ_CYCLES=8 so one launch occupies 12 busy cycles.
module tb_wave_led_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b, abort;
  logic [2:0] code_a, code_b;
  logic       ack_a, ack_b;
  logic [2:0] signal;
  logic       start_sequence, busy, fifo_full;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;

  logic [2:0] lq[$];
  logic       prev_start = 1'b0;

  wave_led_scheduler #(
    .FIFO_DEPTH   (4),
    .START_CYCLES (2),
    .SEQ_CYCLES   (8),
    .GAP_CYCLES   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_a          (req_a),
    .code_a         (code_a),
    .ack_a          (ack_a),
    .req_b          (req_b),
    .code_b         (code_b),
    .ack_b          (ack_b),
    .abort          (abort),
    .signal         (signal),
    .start_sequence (start_sequence),
    .busy           (busy),
    .fifo_full      (fifo_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (start_sequence && !prev_start) lq.push_back(signal);
    prev_start = start_sequence;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [2:0] c, output int rel,
                         output bit ok);
    req_a  = 1'b1;
    code_a = c;
    ok     = 1'b0;
    rel    = -1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (ack_a) begin
        ok  = 1'b1;
        rel = cyc - t0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = 0; req_b = 0; abort = 0;
    code_a = 0; code_b = 0;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({signal, start_sequence, busy, ack_a, ack_b, fifo_full} !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0",
               {signal, start_sequence, busy, ack_a, ack_b, fifo_full});
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if ({signal, start_sequence, busy, ack_a, ack_b, fifo_full} !== 8'd0) begin
        bad++;
        $display("FAIL idle_cycle%0d got=%b want=0", i,
                 {signal, start_sequence, busy, ack_a, ack_b, fifo_full});
      end
    end
  endtask

  task automatic test_single();
    int rel;
    bit ok;
    tick(); t0 = cyc; lq.delete();
    drive_a(3'd1, rel, ok);
    req_a = 1'b0;
    total++;
    if (!ok || rel != 1) begin
      bad++; $display("FAIL single_ack got=%0d want=1", rel);
    end
    tick();
    total++;
    if ({signal, start_sequence, busy, ack_a} !== 6'b001_1_1_0) begin
      bad++;
      $display("FAIL single_c2 got=%b want=001110",
               {signal, start_sequence, busy, ack_a});
    end
    tick();
    total++;
    if (start_sequence !== 1'b1) begin
      bad++; $display("FAIL single_start_c3 got=%b want=1", start_sequence);
    end
    tick();
    total++;
    if ({start_sequence, busy} !== 2'b01) begin
      bad++;
      $display("FAIL single_run_c4 got=%b want=01", {start_sequence, busy});
    end
    while (cyc - t0 < 13) tick();
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL single_busy_c13 got=%b want=1", busy);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL single_busy_c14 got=%b want=0", busy);
    end
    while (cyc - t0 < 20) tick();
    total++;
    if ({signal, busy, start_sequence} !== 5'b001_0_0) begin
      bad++;
      $display("FAIL single_hold got=%b want=00100",
               {signal, busy, start_sequence});
    end
  endtask

  task automatic test_contested();
    tick(); t0 = cyc; lq.delete();
    req_a = 1; code_a = 3'd2;
    req_b = 1; code_b = 3'd3;
    tick();
    total++;
    if ({ack_a, ack_b} !== 2'b10) begin
      bad++; $display("FAIL contest_c1 acks got=%b want=10", {ack_a, ack_b});
    end
    req_a = 0;
    tick();
    total++;
    if ({ack_a, ack_b} !== 2'b01) begin
      bad++; $display("FAIL contest_c2 acks got=%b want=01", {ack_a, ack_b});
    end
    req_b = 0;
    total++;
    if ({signal, start_sequence} !== 4'b010_1) begin
      bad++;
      $display("FAIL contest_first got=%b want=0101", {signal, start_sequence});
    end
    while (cyc - t0 < 14) tick();
    total++;
    if ({start_sequence, busy} !== 2'b00) begin
      bad++;
      $display("FAIL contest_c14 got=%b want=00", {start_sequence, busy});
    end
    tick();
    total++;
    if ({signal, start_sequence} !== 4'b011_1) begin
      bad++;
      $display("FAIL contest_second got=%b want=0111", {signal, start_sequence});
    end
    while (cyc - t0 < 35) tick();
    total++;
    if (lq.size() != 2) begin
      bad++; $display("FAIL contest_nlaunch got=%0d want=2", lq.size());
    end else if (lq[0] !== 3'd2 || lq[1] !== 3'd3) begin
      bad++; $display("FAIL contest_order got=%0d,%0d want=2,3", lq[0], lq[1]);
    end
  endtask

  task automatic test_back_to_back();
    int rel;
    bit ok;
    int exp_rel[6] = '{1, 3, 5, 7, 9, 16};
    tick(); t0 = cyc; lq.delete();
    for (int i = 0; i < 6; i++) begin
      drive_a(3'(i + 1), rel, ok);
      total++;
      if (!ok || rel != exp_rel[i]) begin
        bad++;
        $display("FAIL b2b_ack%0d got=%0d want=%0d", i + 1, rel, exp_rel[i]);
      end
      if (i == 4) begin
        total++;
        if (fifo_full !== 1'b1) begin
          bad++; $display("FAIL b2b_full got=%b want=1", fifo_full);
        end
      end
    end
    req_a = 0;
    for (int k = 0; k < 200 && lq.size() < 6; k++) tick();
    total++;
    if (lq.size() != 6) begin
      bad++; $display("FAIL b2b_nlaunch got=%0d want=6", lq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (lq[i] !== 3'(i + 1)) begin
          bad++;
          $display("FAIL b2b_order%0d got=%0d want=%0d", i, lq[i], i + 1);
        end
      end
    end
    for (int k = 0; k < 40 && busy; k++) tick();
    tick();
  endtask

  task automatic test_abort();
    int rel;
    bit ok;
    tick(); t0 = cyc; lq.delete();
    drive_a(3'd4, rel, ok);
    drive_a(3'd5, rel, ok);
    drive_a(3'd6, rel, ok);
    req_a = 0;
    total++;
    if (!ok || rel != 5) begin
      bad++; $display("FAIL abort_setup_ack got=%0d want=5", rel);
    end
    while (cyc - t0 < 7) tick();
    total++;
    if ({busy, start_sequence} !== 2'b10) begin
      bad++; $display("FAIL abort_in_run got=%b want=10", {busy, start_sequence});
    end
    abort = 1; req_b = 1; code_b = 3'd3;
    tick();
    abort = 0;
    total++;
    if ({signal, start_sequence, busy, fifo_full, ack_b} !== 7'd0) begin
      bad++;
      $display("FAIL abort_next got=%b want=0",
               {signal, start_sequence, busy, fifo_full, ack_b});
    end
    req_b = 0;
    lq.delete();
    for (int k = 0; k < 30; k++) tick();
    total++;
    if (lq.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_quiet launches=%0d busy=%b want 0,0", lq.size(), busy);
    end
    tick(); t0 = cyc;
    drive_a(3'd7, rel, ok);
    req_a = 0;
    for (int k = 0; k < 20; k++) tick();
    total++;
    if (lq.size() != 1) begin
      bad++; $display("FAIL abort_relaunch_n got=%0d want=1", lq.size());
    end else if (lq[0] !== 3'd7) begin
      bad++; $display("FAIL abort_relaunch_code got=%0d want=7", lq[0]);
    end
  endtask

  task automatic test_repeat();
    int rel;
    bit ok;
    tick(); t0 = cyc; lq.delete();
    drive_a(3'd5, rel, ok);
    req_a = 0;
`ifdef WAVE_LED_SCHED_REPEAT_EN
    while (cyc - t0 < 45) tick();
    total++;
    if (lq.size() != 4) begin
      bad++; $display("FAIL repeat_n got=%0d want=4", lq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (lq[i] !== 3'd5) begin
          bad++; $display("FAIL repeat_code%0d got=%0d want=5", i, lq[i]);
        end
      end
    end
    drive_a(3'd2, rel, ok);
    req_a = 0;
    while (cyc - t0 < 60) tick();
    total++;
    if (lq.size() != 5) begin
      bad++; $display("FAIL repeat_takeover_n got=%0d want=5", lq.size());
    end else if (lq[4] !== 3'd2) begin
      bad++; $display("FAIL repeat_takeover got=%0d want=2", lq[4]);
    end
    abort = 1;
    tick();
    abort = 0;
    lq.delete();
    for (int k = 0; k < 30; k++) tick();
    total++;
    if (lq.size() != 0) begin
      bad++; $display("FAIL repeat_abort got=%0d want=0", lq.size());
    end
`else
    while (cyc - t0 < 50) tick();
    total++;
    if (lq.size() != 1) begin
      bad++; $display("FAIL once_n got=%0d want=1", lq.size());
    end else if (lq[0] !== 3'd5) begin
      bad++; $display("FAIL once_code got=%0d want=5", lq[0]);
    end
    total++;
    if ({busy, signal} !== 4'b0_101) begin
      bad++; $display("FAIL once_idle got=%b want=0101", {busy, signal});
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_contested();
    test_back_to_back();
    test_abort();
    test_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
